// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, zero-register constant and writeback requester IDs
package cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
endpackage

// File: rtl/wb_slot.sv
// wb_slot: one-entry writeback holding register with full flag and relative age bit
module wb_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              other_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic              old,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  // old=1 means this entry was accepted strictly before the other slot's entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      full <= 1'b0;
      old  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      full <= load | (full & ~clear);
      old  <= load ? 1'b0 : other_load ? 1'b1 : old;
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two writeback requesters,
// oldest-first with round-robin on ties, and exports a pending-write bitmap for hazard stalls
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending
);
  logic              a_full, a_old, b_full, b_old;
  logic [ADDR_W-1:0] a_saddr, b_saddr;
  logic [DATA_W-1:0] a_sdata, b_sdata;
  logic              tie, grant_a, grant_b, load_a, load_b;
  req_id_e           rr;
  // grants depend only on slot state, so ready never depends on valid
  assign tie     = a_full & b_full & (a_old == b_old);
  assign grant_a = a_full & (~b_full | (a_old & ~b_old) | (tie & (rr == REQ_A)));
  assign grant_b = b_full & ~grant_a;
  assign a_ready = ~a_full | grant_a;
  assign b_ready = ~b_full | grant_b;
  assign load_a  = a_valid & a_ready & (a_addr != ADDR_W'(REG_ZERO));
  assign load_b  = b_valid & b_ready & (b_addr != ADDR_W'(REG_ZERO));
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk(clk), .reset(reset), .load(load_a), .clear(grant_a), .other_load(load_b),
    .load_addr(a_addr), .load_data(a_data),
    .full(a_full), .old(a_old), .addr(a_saddr), .data(a_sdata)
  );
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk(clk), .reset(reset), .load(load_b), .clear(grant_b), .other_load(load_a),
    .load_addr(b_addr), .load_data(b_data),
    .full(b_full), .old(b_old), .addr(b_saddr), .data(b_sdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr       <= REQ_A;
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (tie) rr <= (rr == REQ_A) ? REQ_B : REQ_A;
      rf_write <= grant_a | grant_b;
      if (grant_a | grant_b) begin
        rf_waddr <= grant_a ? a_saddr : b_saddr;
        rf_wdata <= grant_a ? a_sdata : b_sdata;
      end
    end
  always_comb begin
    pending = '0;
    if (a_full) pending[a_saddr] = 1'b1;
    if (b_full) pending[b_saddr] = 1'b1;
    if (rf_write) pending[rf_waddr] = 1'b1;
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of acceptance, ordering, tie-break, zero register and reset
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata, pending;
  logic        rf_write;
  logic [31:0] rf_model [32];
  int          total = 0;
  int          bad = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  // register file commits on the falling edge
  always @(negedge clk)
    if (!reset) for (int i = 0; i < 32; i++) rf_model[i] <= '0;
    else if (rf_write) rf_model[rf_waddr] <= rf_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 64'(rf_write), 64'd1);
    chk({tag, "_addr"}, 64'(rf_waddr), 64'(addr));
    chk({tag, "_data"}, 64'(rf_wdata), 64'(data));
  endtask

  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    a_valid = v; a_addr = ad; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    b_valid = v; b_addr = ad; b_data = d;
  endtask

  initial begin
    reset = 1'b0;
    drive_a(1'b1, 5'd9, 32'h99);
    drive_b(1'b1, 5'd10, 32'hA0);
    #1;
    chk("rst_we0", 64'(rf_write), 64'd0);
    repeat (2) step();
    chk("rst_we", 64'(rf_write), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_ardy", 64'(a_ready), 64'd1);
    chk("rst_brdy", 64'(b_ready), 64'd1);
    reset = 1'b1;
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    chk("rel_we", 64'(rf_write), 64'd0);
    chk("rel_pend", 64'(pending), 64'h600);
    chk("rel_brdy", 64'(b_ready), 64'd0);
    chk("rel_ardy", 64'(a_ready), 64'd1);
    step();
    chk_wr("rel_w1", 5'd9, 32'h99);
    chk("rel_pend1", 64'(pending), 64'h600);
    step();
    chk_wr("rel_w2", 5'd10, 32'hA0);
    chk("rel_pend2", 64'(pending), 64'h400);
    step();
    chk("rel_idle", 64'(rf_write), 64'd0);
    chk("rel_hold", 64'(rf_waddr), 64'd10);
    chk("rel_pend3", 64'(pending), 64'd0);

    drive_a(1'b1, 5'd3, 32'h11);
    step();
    chk("ss_pend", 64'(pending), 64'h8);
    drive_a(1'b1, 5'd4, 32'h22);
    chk("ss_ardy1", 64'(a_ready), 64'd1);
    step();
    chk_wr("ss_w3", 5'd3, 32'h11);
    drive_a(1'b1, 5'd5, 32'h33);
    chk("ss_ardy2", 64'(a_ready), 64'd1);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    chk_wr("ss_w4", 5'd4, 32'h22);
    step();
    chk_wr("ss_w5", 5'd5, 32'h33);
    step();
    chk("ss_idle", 64'(rf_write), 64'd0);

    drive_a(1'b1, 5'd1, 32'hAAAA);
    drive_b(1'b1, 5'd2, 32'hBBBB);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("tie1_first", 5'd2, 32'hBBBB);
    step();
    chk_wr("tie1_second", 5'd1, 32'hAAAA);
    step();
    chk("tie1_idle", 64'(rf_write), 64'd0);
    drive_a(1'b1, 5'd1, 32'hAAAA);
    drive_b(1'b1, 5'd2, 32'hBBBB);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("tie2_first", 5'd1, 32'hAAAA);
    step();
    chk_wr("tie2_second", 5'd2, 32'hBBBB);
    step();
    chk("tie2_idle", 64'(rf_write), 64'd0);

    drive_a(1'b1, 5'd8, 32'h8);
    drive_b(1'b1, 5'd9, 32'h9);
    step();
    chk("old_ardy", 64'(a_ready), 64'd0);
    chk("old_brdy", 64'(b_ready), 64'd1);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b1, 5'd7, 32'h1);
    step();
    chk_wr("old_w9", 5'd9, 32'h9);
    chk("old_p7a", 64'(pending[7]), 64'd1);
    drive_b(1'b0, 5'd0, 32'h0);
    drive_a(1'b1, 5'd7, 32'h2);
    chk("old_ardy2", 64'(a_ready), 64'd1);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    chk_wr("old_w8", 5'd8, 32'h8);
    chk("old_p7b", 64'(pending[7]), 64'd1);
    step();
    chk_wr("old_w7a", 5'd7, 32'h1);
    chk("old_p7c", 64'(pending[7]), 64'd1);
    step();
    chk_wr("old_w7b", 5'd7, 32'h2);
    chk("old_p7d", 64'(pending[7]), 64'd1);
    step();
    chk("old_idle", 64'(rf_write), 64'd0);
    chk("old_pend", 64'(pending), 64'd0);
    chk("old_r7", 64'(rf_model[7]), 64'h2);

    drive_a(1'b1, 5'd0, 32'hDEAD);
    chk("z_ardy", 64'(a_ready), 64'd1);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    chk("z_pend", 64'(pending), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("z_we", 64'(rf_write), 64'd0);
      step();
    end
    chk("z_r0", 64'(rf_model[0]), 64'd0);

    drive_a(1'b1, 5'd11, 32'hB1);
    drive_b(1'b1, 5'd12, 32'hB2);
    step();
    drive_b(1'b0, 5'd0, 32'h0);
    drive_a(1'b1, 5'd13, 32'hC3);
    step();
    drive_a(1'b0, 5'd0, 32'h0);
    chk_wr("mr_w11", 5'd11, 32'hB1);
    chk("mr_pend", 64'(pending), 64'h3800);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_we", 64'(rf_write), 64'd0);
    chk("mr_pend0", 64'(pending), 64'd0);
    chk("mr_waddr", 64'(rf_waddr), 64'd0);
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_after_we", 64'(rf_write), 64'd0);
    end
    chk("mr_r12", 64'(rf_model[12]), 64'd0);
    chk("mr_r13", 64'(rf_model[13]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (memory load).
- Each requester has a valid/ready handshake and a one-entry holding slot; the block arbitrates oldest-first, with round-robin on ties.
- Drives registered write-port signals (rf_write/rf_waddr/rf_wdata) into the register file, which commits them on the falling clock edge.
- Exports a pending-write bitmap so issue logic can stall on RAW hazards.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width; pending width is 2**ADDR_W.

Ports:
- clk  in  1  system clock; all block state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's slot can accept this cycle.
- a_addr  in  ADDR_W  A's destination register.
- a_data  in  DATA_W  A's write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's slot can accept this cycle.
- b_addr  in  ADDR_W  B's destination register.
- b_data  in  DATA_W  B's write data.
- rf_write  out  1  write-enable to register file.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- pending  out  2**ADDR_W  bit i=1 while a write to register i is buffered or on the write port.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both slots empty; rf_write=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer = A; pending=0.
  - Any in-flight writes are discarded.
- Acceptance:
  - A transfer occurs on a rising edge when X_valid && X_ready.
  - The slot captures addr/data and an age stamp.
  - X_addr==0: the handshake completes but the request is dropped; the slot is not loaded and no write ever occurs.
- Ready:
  - X_ready = !slot_X_full || grant_X.
  - grant_X is decoded from registered state only, so there is no combinational path from valid to ready.
  - A single requester therefore sustains one write per cycle.
- Arbitration, every cycle:
  - Only one slot full: grant it.
  - Both full: grant the older entry (earlier acceptance edge).
  - Both loaded on the same edge: grant the rr pointer side, then toggle the pointer.
  - The pointer changes only on tie-breaks.
- Grant:
  - At the rising edge, the granted slot's addr/data load rf_waddr/rf_wdata, rf_write=1, and the slot is freed.
  - With no grant: rf_write=0; rf_waddr and rf_wdata hold their values.
- Latency: accepted at edge N → rf_write high from edge N+1 → register file commits on the falling edge within cycle N+1.
- Ordering: two writes to the same register always commit in acceptance order; the oldest-first rule guarantees this.
- Same register, same edge, both requesters: commit order follows rr. The producer must not issue this case; the bench checks that it does not hang.
- pending:
  - Combinational OR of one-hot(slot_A.addr) if full, one-hot(slot_B.addr) if full, and one-hot(rf_waddr) if rf_write.
  - Bit 0 is always 0.
- Starvation: worst-case wait for a full slot is one grant cycle.
- Back-to-back refill: accept and grant on the same slot in the same edge is legal. The new entry's age is newer than the other slot's.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (5'd0).
  - Requester-ID encoding: REQ_A=0, REQ_B=1.
- Sub-module wb_slot: one-entry holding register with full flag, addr, data and age bit.
  - Inputs: load, clear, and age update on the other slot's load.
  - Instantiated twice.

Test Plan:
- Reset: hold reset=0 with a_valid=b_valid=1 → rf_write=0, pending=0, a_ready=b_ready=1. Release reset → first grant on the following edge.
- Single stream: A sends r3=0x11, r4=0x22, r5=0x33 on consecutive cycles, b_valid=0 → rf_write high for 3 consecutive cycles with the same order, each one edge after acceptance, and a_ready stays 1.
- Simultaneous tie: A r1=0xAAAA, B r2=0xBBBB on the same edge, pointer=A → r1 written first, then r2. Repeat → B first this time.
- Oldest-first ordering: B r7=0x1 accepted at edge N while the port is busy, A r7=0x2 at edge N+1 → r7 final value 0x2. pending[7]=1 until the second write leaves the port.
- Zero register: A r0=0xDEAD → handshake completes, rf_write never asserts, pending[0]=0.
- Reset mid-operation: both slots full, assert reset asynchronously between edges → rf_write drops immediately, pending=0, and neither buffered write ever appears.
